// File: rtl/nco_fsk_pkg.sv
// nco_fsk_pkg: shared state type, default widths and the symbol-to-increment mapping for the FSK sequencer.
package nco_fsk_pkg;
  localparam int APR_D = 32;
  localparam int BPS_D = 2;
  localparam int SPS_W_D = 16;
  typedef enum logic {IDLE, ACTIVE} state_t;
  // Computed wide and truncated by the caller; low APR bits equal (base + sym*step) mod 2^APR.
  function automatic logic [63:0] tone_inc(input logic [63:0] base, input logic [63:0] step, input logic [7:0] sym);
    logic [63:0] acc;
    acc = base;
    for (int i = 0; i < 8; i++) if (sym[i]) acc = acc + (step << i);
    return acc;
  endfunction
endpackage

// File: rtl/nco_fsk_ramp.sv
// nco_fsk_ramp: glides the increment toward a new tone over 2^RAMP_LOG2 samples, snapping to the exact target on the last one.
module nco_fsk_ramp #(
  parameter int APR = 32,
  parameter int SPS_W = 16,
  parameter int RAMP_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic             ramp_ok,
  input  logic [APR-1:0]   target,
  input  logic [APR-1:0]   cur,
  input  logic [SPS_W-1:0] cnt,
  output logic [APR-1:0]   next_inc
);
  localparam int RL = 1 << RAMP_LOG2;
  logic [APR-1:0] delta, delta_now, tgt;
  logic on;
  assign delta_now = APR'($signed(target - cur) >>> RAMP_LOG2);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      delta <= '0;
      tgt <= '0;
      on <= 1'b0;
    end else if (enable && load) begin
      delta <= delta_now;
      tgt <= target;
      on <= ramp_ok;
    end
  end
  // The load edge produces sample 1; the edge at cnt==RL-2 produces sample RL, the exact target.
  always_comb
    next_inc = load ? (ramp_ok ? cur + delta_now : target)
             : (on && cnt < SPS_W'(RL - 1)) ? (cnt == SPS_W'(RL - 2) ? tgt : cur + delta)
             : cur;
endmodule

// File: rtl/nco_fsk_inc_seq.sv
// nco_fsk_inc_seq: maps a valid/ready symbol stream to NCO phase increments held for sps samples each.
// Optional glide between tones when NCO_FSK_RAMP_EN is defined.
module nco_fsk_inc_seq
  import nco_fsk_pkg::*;
#(
  parameter int APR = APR_D,
  parameter int BPS = BPS_D,
  parameter int SPS_W = SPS_W_D,
  parameter int RAMP_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [APR-1:0]   base_inc,
  input  logic [APR-1:0]   step_inc,
  input  logic [SPS_W-1:0] sps,
  input  logic             sym_valid,
  input  logic [BPS-1:0]   sym_data,
  output logic             sym_ready,
  output logic [APR-1:0]   phi_inc_o,
  output logic             nco_clken,
  output logic             sym_strobe,
  output logic             underrun
);
  state_t state, state_n;
  logic [SPS_W-1:0] cnt, cnt_n, sps_lat, sps_lat_n, lat_new;
  logic [APR-1:0] phi_n, tone;
  logic accept, at_end;
  assign lat_new = (sps == '0) ? SPS_W'(1) : sps;
  assign at_end = (state == ACTIVE) && (cnt == sps_lat - SPS_W'(1));
  assign sym_ready = reset_n && enable && (state == IDLE || at_end);
  assign accept = sym_valid && sym_ready;
  assign tone = APR'(tone_inc(64'(base_inc), 64'(step_inc), 8'(sym_data)));
`ifdef NCO_FSK_RAMP_EN
  logic [APR-1:0] ramp_inc;
  nco_fsk_ramp #(.APR(APR), .SPS_W(SPS_W), .RAMP_LOG2(RAMP_LOG2)) u_ramp (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .load(accept),
    .ramp_ok(lat_new >= SPS_W'(1 << RAMP_LOG2)),
    .target(tone),
    .cur(phi_inc_o),
    .cnt(cnt),
    .next_inc(ramp_inc)
  );
`endif
  always_comb begin
    state_n = accept ? ACTIVE : (at_end ? IDLE : state);
    cnt_n = (accept || state_n == IDLE) ? '0 : cnt + SPS_W'(1);
    sps_lat_n = accept ? lat_new : sps_lat;
`ifdef NCO_FSK_RAMP_EN
    phi_n = (!accept && (state == IDLE || at_end)) ? base_inc : ramp_inc;
`else
    phi_n = accept ? tone : (state == IDLE || at_end) ? base_inc : phi_inc_o;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      sps_lat <= SPS_W'(1);
      phi_inc_o <= '0;
      nco_clken <= 1'b0;
      sym_strobe <= 1'b0;
      underrun <= 1'b0;
    end else begin
      nco_clken <= enable;
      sym_strobe <= accept;
      underrun <= enable && at_end && !accept;
      if (enable) begin
        state <= state_n;
        cnt <= cnt_n;
        sps_lat <= sps_lat_n;
        phi_inc_o <= phi_n;
      end
    end
  end
endmodule

// File: tb/tb_nco_fsk_inc_seq.sv
// tb_nco_fsk_inc_seq: directed and randomized checks of the FSK increment sequencer against a samples-remaining model.
module tb_nco_fsk_inc_seq;
  logic clk = 0, reset_n = 0, enable = 0, sym_valid = 0;
  logic [31:0] base_inc = 0, step_inc = 0;
  logic [15:0] sps = 0;
  logic [1:0] sym_data = 0;
  logic sym_ready, nco_clken, sym_strobe, underrun;
  logic [31:0] phi_inc_o;
  int checks = 0, errors = 0;
  bit m_idle = 1, m_clken = 0, m_strobe = 0, m_under = 0;
  int m_rem = 0;
  logic [31:0] m_inc = 0;

  nco_fsk_inc_seq dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .base_inc(base_inc), .step_inc(step_inc),
    .sps(sps), .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .phi_inc_o(phi_inc_o), .nco_clken(nco_clken), .sym_strobe(sym_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check ready before the edge, advance the model, check registered outputs after it.
  task automatic step(input logic rn, input logic en, input logic v, input logic [1:0] d);
    bit rdy, acc;
    @(negedge clk);
    reset_n = rn; enable = en; sym_valid = v; sym_data = d;
    #1;
    rdy = rn && en && (m_idle || m_rem == 1);
    acc = v && rdy;
    chk("sym_ready", {31'b0, sym_ready}, {31'b0, rdy});
    @(posedge clk);
    if (!rn) begin
      m_idle = 1; m_rem = 0; m_inc = 0; m_clken = 0; m_strobe = 0; m_under = 0;
    end else begin
      m_clken = en;
      m_strobe = acc;
      m_under = en && !m_idle && m_rem == 1 && !acc;
      if (en) begin
        if (acc) begin
          m_inc = base_inc + 32'(d) * step_inc;
          m_rem = (sps == 0) ? 1 : int'(sps);
          m_idle = 0;
        end else if (m_idle || m_rem == 1) begin
          m_idle = 1;
          m_inc = base_inc;
        end else m_rem--;
      end
    end
    #1;
    chk("phi_inc_o", phi_inc_o, m_inc);
    chk("nco_clken", {31'b0, nco_clken}, {31'b0, m_clken});
    chk("sym_strobe", {31'b0, sym_strobe}, {31'b0, m_strobe});
    chk("underrun", {31'b0, underrun}, {31'b0, m_under});
  endtask

  initial begin
    base_inc = 32'h0100_0000; step_inc = 32'h0010_0000; sps = 4;
    repeat (3) step(0, 1, 1, 0);
    chk("rst_phi", phi_inc_o, 0);
    step(1, 1, 0, 0);
    chk("idle_base", phi_inc_o, 32'h0100_0000);
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) begin
        step(1, 1, 1, 2'(s));
        chk("b2b_tone", phi_inc_o, 32'h0100_0000 + 32'(s) * 32'h0010_0000);
        chk("b2b_no_underrun", {31'b0, underrun}, 0);
      end
    step(1, 1, 0, 0);
    chk("end_underrun", {31'b0, underrun}, 1);
    step(1, 1, 1, 3);
    repeat (3) step(1, 1, 0, 0);
    chk("single_hold", phi_inc_o, 32'h0130_0000);
    step(1, 1, 0, 0);
    chk("single_base", phi_inc_o, 32'h0100_0000);
    chk("single_underrun", {31'b0, underrun}, 1);
    step(1, 1, 1, 2);
    step(1, 1, 0, 0);
    repeat (5) step(1, 0, 1, 1);
    chk("freeze_phi", phi_inc_o, 32'h0120_0000);
    chk("freeze_clken", {31'b0, nco_clken}, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("freeze_span", phi_inc_o, 32'h0120_0000);
    step(1, 1, 0, 0);
    chk("freeze_end", phi_inc_o, 32'h0100_0000);
    sps = 0; base_inc = 32'hFFF0_0000;
    step(1, 1, 1, 1);
    chk("wrap_sym1", phi_inc_o, 32'h0000_0000);
    step(1, 1, 1, 3);
    chk("wrap_sym3", phi_inc_o, 32'h0020_0000);
    chk("sps0_strobe", {31'b0, sym_strobe}, 1);
    step(1, 1, 0, 0);
    chk("sps0_underrun", {31'b0, underrun}, 1);
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) begin
        sps = 16'($urandom_range(0, 6));
        base_inc = $urandom;
        step_inc = $urandom;
      end
      step($urandom_range(0, 40) != 0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, 2'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
